// File: rtl/disp_scan_ctrl.sv
// Scan controller that shares one hex-to-7-segment decoder across NUM_DIGITS
// common-anode digits, with a blanking guard per slot and frame-aligned value updates.
module disp_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_load,
  input  logic [4*NUM_DIGITS-1:0]       i_value_in,
  input  logic                          i_lz_en,
  output logic [3:0]                    o_num_act,
  output logic                          o_seg_blank,
  output logic [NUM_DIGITS-1:0]         o_digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
  output logic                          o_pending,
  output logic                          o_frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(DIV);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] C_GUARD_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] C_SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] C_IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] C_IDX_ZERO   = IW'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [DW-1:0]           r_disp;
  logic [DW-1:0]           r_shadow;
  logic                    r_pending;
  logic [3:0]              r_num_act;
  logic                    r_seg_blank;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic [IW-1:0]           r_digit_idx;
  logic                    r_frame_done;

  state_t                  w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic [DW-1:0]           w_disp_nxt;
  logic [DW-1:0]           w_shadow_nxt;
  logic                    w_pending_nxt;
  logic                    w_boundary;
  logic [3:0]              w_num_act;
  logic                    w_seg_blank;
  logic [NUM_DIGITS-1:0]   w_digit_sel;
  logic [IW-1:0]           w_digit_idx;

  // A digit above 0 is dark when it and every more significant nibble are zero.
  function automatic logic f_suppressed(input logic [DW-1:0] disp,
                                        input logic [IW-1:0] idx,
                                        input logic          lz);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      all_zero = all_zero & ~((k >= int'(idx)) & (|disp[4*k +: 4]));
    end
    return lz & (idx != C_IDX_ZERO) & all_zero;
  endfunction

  function automatic logic [3:0] f_nibble(input logic [DW-1:0] disp,
                                          input logic [IW-1:0] idx);
    return disp[{idx, 2'b00} +: 4];
  endfunction

  // Next-state logic: slot timing, digit stepping, load capture and frame commit.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_disp_nxt    = r_disp;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_boundary    = 1'b0;

    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = C_IDX_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = C_IDX_ZERO;
        end
        S_GUARD: begin
          w_cnt_nxt = r_cnt + C_CNT_ONE;
          if (r_cnt == C_GUARD_LAST) begin
            w_state_nxt = S_DRIVE;
          end else begin
            w_state_nxt = S_GUARD;
          end
        end
        S_DRIVE: begin
          if (r_cnt == C_SLOT_LAST) begin
            w_state_nxt = S_GUARD;
            w_cnt_nxt   = '0;
            if (r_idx == C_IDX_LAST) begin
              w_idx_nxt  = C_IDX_ZERO;
              w_boundary = 1'b1;
            end else begin
              w_idx_nxt  = r_idx + C_IDX_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = C_IDX_ZERO;
        end
      endcase
    end

    // Commit uses the old shadow, so a coincident load survives as the next pending value.
    if (r_state == S_IDLE) begin
      if (i_load) begin
        w_disp_nxt = i_value_in;
      end else begin
        w_disp_nxt = r_disp;
      end
    end else begin
      if (w_boundary && r_pending) begin
        w_disp_nxt    = r_shadow;
        w_pending_nxt = 1'b0;
      end else begin
        w_disp_nxt    = r_disp;
      end
      if (i_load) begin
        w_shadow_nxt  = i_value_in;
        w_pending_nxt = 1'b1;
      end else begin
        w_shadow_nxt  = r_shadow;
      end
    end
  end

  // Output decode from next-state values so registered outputs line up with the state.
  always_comb begin
    w_num_act   = 4'd0;
    w_seg_blank = 1'b1;
    w_digit_sel = {NUM_DIGITS{1'b1}};
    w_digit_idx = C_IDX_ZERO;
    case (w_state_nxt)
      S_GUARD: begin
        w_num_act   = f_nibble(w_disp_nxt, w_idx_nxt);
        w_digit_idx = w_idx_nxt;
      end
      S_DRIVE: begin
        w_num_act              = f_nibble(w_disp_nxt, w_idx_nxt);
        w_digit_idx            = w_idx_nxt;
        w_digit_sel[w_idx_nxt] = 1'b0;
        w_seg_blank            = f_suppressed(w_disp_nxt, w_idx_nxt, i_lz_en);
      end
      S_IDLE: begin
        w_num_act   = 4'd0;
        w_digit_idx = C_IDX_ZERO;
      end
      default: begin
        w_num_act   = 4'd0;
        w_digit_idx = C_IDX_ZERO;
      end
    endcase
  end

  // State, data and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= C_IDX_ZERO;
      r_disp       <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_num_act    <= 4'd0;
      r_seg_blank  <= 1'b1;
      r_digit_sel  <= {NUM_DIGITS{1'b1}};
      r_digit_idx  <= C_IDX_ZERO;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_disp       <= w_disp_nxt;
      r_shadow     <= w_shadow_nxt;
      r_pending    <= w_pending_nxt;
      r_num_act    <= w_num_act;
      r_seg_blank  <= w_seg_blank;
      r_digit_sel  <= w_digit_sel;
      r_digit_idx  <= w_digit_idx;
      r_frame_done <= w_boundary;
    end
  end

  assign o_num_act    = r_num_act;
  assign o_seg_blank  = r_seg_blank;
  assign o_digit_sel  = r_digit_sel;
  assign o_digit_idx  = r_digit_idx;
  assign o_pending    = r_pending;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random traffic, checked every
// cycle against a position-in-frame reference model.
module tb_disp_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int B     = 2;
  localparam int FRAME = N * DIV;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ld;
  logic [15:0] val;
  logic        lz;
  logic [3:0]  num_act;
  logic        seg_blank;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // reference model: enabled/idle flag, cycles since scan start, registers
  bit          m_active;
  int          m_pos;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  bit          m_pend;
  bit          m_fd;

  disp_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(B)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_load       (ld),
    .i_value_in   (val),
    .i_lz_en      (lz),
    .o_num_act    (num_act),
    .o_seg_blank  (seg_blank),
    .o_digit_sel  (digit_sel),
    .o_digit_idx  (digit_idx),
    .o_pending    (pending),
    .o_frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int slot_of();
    return (m_pos / DIV) % N;
  endfunction

  function automatic int phase_of();
    return m_pos % DIV;
  endfunction

  // One clock: advance the model from the spec's rules, then compare every output.
  task automatic step();
    bit          bnd;
    int          slot;
    int          phase;
    logic [3:0]  e_sel;
    logic        e_blank;
    logic [15:0] upper;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_pos = 0; m_disp = 16'h0; m_shadow = 16'h0;
      m_pend = 1'b0; m_fd = 1'b0;
    end else begin
      bnd = m_active && en && (m_pos % FRAME == FRAME - 1);
      if (!m_active) begin
        if (ld) m_disp = val;
      end else begin
        if (bnd && m_pend) begin
          m_disp = m_shadow;
          m_pend = 1'b0;
        end
        if (ld) begin
          m_shadow = val;
          m_pend = 1'b1;
        end
      end
      if (!en) begin
        m_active = 1'b0; m_pos = 0;
      end else if (!m_active) begin
        m_active = 1'b1; m_pos = 0;
      end else begin
        m_pos++;
      end
      m_fd = bnd;
    end
    #1;
    if (!m_active) begin
      chk("sel_idle", digit_sel, 4'b1111);
      chk("blank_idle", seg_blank, 1'b1);
      chk("idx_idle", digit_idx, 2'd0);
    end else begin
      slot  = slot_of();
      phase = phase_of();
      upper = m_disp >> (4 * slot);
      if (phase < B) begin
        e_sel   = 4'b1111;
        e_blank = 1'b1;
      end else begin
        e_sel   = ~(4'b0001 << slot);
        e_blank = lz && (slot > 0) && (upper == 16'h0);
      end
      chk("sel", digit_sel, e_sel);
      chk("blank", seg_blank, e_blank);
      chk("idx", digit_idx, slot);
      chk("num", num_act, upper & 16'hF);
    end
    chk("pending", pending, m_pend);
    chk("frame_done", frame_done, m_fd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model sits at (slot, phase); the next step's edge acts there.
  task automatic wait_pos(input string tag, input int slot, input int phase);
    int n;
    n = 0;
    while (!(m_active && slot_of() == slot && phase_of() == phase) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL wait_%s observed=timeout expected=reached", tag);
    end
  endtask

  task automatic load_once(input logic [15:0] v);
    ld = 1'b1; val = v;
    step();
    ld = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_num", num_act, 4'd0);
    chk("rst_sel", digit_sel, 4'b1111);
    chk("rst_blank", seg_blank, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_pend", pending, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; val = 16'h0; lz = 1'b0;
    run(3);
    chk_reset_vals();
    rst = 1'b0;

    // 0x1234 loaded in idle, then two full frames
    load_once(16'h1234);
    en = 1'b1;
    run(3);
    chk("first_guard_end_sel", digit_sel, 4'b1110);
    chk("first_drive_num", num_act, 4'd4);
    run(2 * FRAME);

    // 0xBEEF loaded in idle goes straight to the display
    en = 1'b0;
    run(2);
    load_once(16'hBEEF);
    chk("idle_load_no_pend", pending, 1'b0);
    en = 1'b1;
    run(FRAME + 4);

    // load while digit 1 is scanning; commits at the next boundary
    wait_pos("d1", 1, 3);
    load_once(16'h00A5);
    chk("pend_set", pending, 1'b1);
    run(2 * FRAME);

    // leading-zero suppression for 0x0005 then 0x0000
    lz = 1'b1;
    load_once(16'h0005);
    run(2 * FRAME);
    load_once(16'h0000);
    run(2 * FRAME);
    lz = 1'b0;

    // drop enable mid-drive of digit 2, then restart
    wait_pos("d2", 2, 4);
    en = 1'b0;
    step();
    chk("abort_sel", digit_sel, 4'b1111);
    chk("abort_idx", digit_idx, 2'd0);
    chk("abort_fd", frame_done, 1'b0);
    run(3);
    en = 1'b1;
    run(FRAME + 2);

    // load exactly at the boundary while another value is pending
    wait_pos("mid", 1, 0);
    load_once(16'h1111);
    wait_pos("bnd", N - 1, DIV - 1);
    load_once(16'h2222);
    chk("bnd_fd", frame_done, 1'b1);
    chk("bnd_pend", pending, 1'b1);
    run(B);
    chk("bnd_old_shadow", num_act, 4'h1);
    run(2 * FRAME);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      en  = ($urandom_range(0, 29) != 0);
      ld  = ($urandom_range(0, 11) == 0);
      val = 16'($urandom);
      lz  = 1'($urandom_range(0, 1));
      step();
    end
    ld = 1'b0; en = 1'b1;

    // reset in mid-operation with a load pending
    run(5);
    load_once(16'hCAFE);
    rst = 1'b1;
    step();
    chk_reset_vals();
    rst = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexes one hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Each cycle it presents one nibble to the shared decoder and drives the matching active-low digit enable.
- It inserts a ghosting guard interval between digits and takes new display values through a load handshake.
- New values are committed only at frame boundaries, so no frame shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; digit 0 = least significant.
- DIV, 50000, clock cycles per digit slot (guard + drive); DIV > BLANK_CYCLES.
- BLANK_CYCLES, 500, guard cycles at slot start with all digits off; >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  1 = scan; 0 = all digits off, return to IDLE.
- load  input  1  single-cycle strobe; capture value_in.
- value_in  input  4*NUM_DIGITS  nibble i = digit i.
- lz_en  input  1  leading-zero suppression enable.
- numAct  output  4  nibble to the shared decoder.
- seg_blank  output  1  1 = force all segments off downstream of the decoder.
- digit_sel  output  NUM_DIGITS  active-low digit enables, at most one bit low.
- digit_idx  output  clog2(NUM_DIGITS)  current digit index.
- pending  output  1  a loaded value is waiting for the next frame boundary.
- frame_done  output  1  one-cycle pulse after the last digit's slot.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- All outputs are registered.
- Reset values:
  - state = IDLE, digit_sel = all 1s, digit_idx = 0, numAct = 0.
  - seg_blank = 1, pending = 0, frame_done = 0.
  - Display register = 0, shadow register = 0, slot counter = 0.
- State machine: IDLE, GUARD, DRIVE.
- IDLE:
  - digit_sel all 1s, seg_blank = 1.
  - When enable = 1: next cycle go to GUARD with digit_idx = 0 and counter = 0.
- GUARD:
  - Lasts exactly BLANK_CYCLES cycles.
  - digit_sel all 1s, seg_blank = 1, numAct = display nibble[digit_idx].
  - Then go to DRIVE.
- DRIVE:
  - Lasts exactly DIV - BLANK_CYCLES cycles.
  - digit_sel[digit_idx] = 0, all other bits 1.
  - seg_blank = suppressed(digit_idx).
  - At the end of DRIVE: digit_idx increments, wrapping NUM_DIGITS-1 -> 0, and the state returns to GUARD.
- Slot period is exactly DIV cycles. Frame period is NUM_DIGITS*DIV cycles.
- Frame boundary (end of DRIVE for digit NUM_DIGITS-1):
  - frame_done = 1 for exactly the first cycle of the next GUARD.
  - If pending = 1: display register <= shadow and pending <= 0, taking effect in that same GUARD.
- enable drops in any state: next cycle go to IDLE, all digits off, digit_idx = 0, counter = 0.
  - No frame_done pulse is produced for an aborted frame.
- Load handshake:
  - In GUARD or DRIVE: load writes shadow <= value_in and sets pending = 1.
  - A repeated load while pending overwrites the shadow; last write wins.
  - If load coincides with a frame-boundary commit, the old shadow is committed and the new value goes into the shadow. pending stays 1.
- In IDLE: load writes the display register directly the next cycle; pending stays 0.
- Leading-zero suppression:
  - Digit i (i > 0) is suppressed when lz_en = 1 and nibbles NUM_DIGITS-1 down to i of the display register are all 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - A suppressed digit still gets its DRIVE slot and digit_sel timing; only seg_blank = 1.
- rst in mid-operation overrides everything, including a pending load and a frame boundary.

Test Plan (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2):
- Reset, then enable=1, display=0x1234.
  - Each digit: GUARD = 2 cycles with digit_sel=1111, then DRIVE = 6 cycles.
  - Sequence: digit_sel 1110 with numAct=4, 1101 with 3, 1011 with 2, 0111 with 1.
  - frame_done pulses every 32 cycles.
- In IDLE, load 0xBEEF, then enable.
  - Digit 0 drives numAct=F; digits 3..0 show B, E, E, F; pending stays 0.
- While scanning digit 1, load 0x00A5.
  - pending=1 until the frame boundary; the following frame shows 0x00A5; pending clears in the frame_done cycle.
- lz_en=1, display 0x0005.
  - seg_blank=1 during the DRIVE slots of digits 3, 2, 1; digit 0 shows 5 with seg_blank=0.
  - Display 0x0000 shows only digit 0 unblanked.
- Drop enable mid-DRIVE of digit 2.
  - Next cycle: digit_sel=1111 and digit_idx=0; no frame_done.
  - Re-enable restarts at digit 0 with GUARD.
- Assert load at the exact boundary cycle with pending=1 (shadow 0x1111, new 0x2222).
  - Next frame shows 0x1111, pending stays 1; the frame after shows 0x2222.
